// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider:
// controller state encoding and the default operand width.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_rca_sub.sv
// Ripple-carry subtractor for the divider's trial subtraction.
// It computes a - b as a + ~b + 1 through a chain of full-adder cells.
// borrow is the inverted final carry, so it is high when a < b.

// Single-bit full-adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_sub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic [N:0] carry;

    // A carry-in of 1 together with the inverted b forms the two's-complement negation.
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            full_adder u_fa (
                .a    (a[gi]),
                .b    (~b[gi]),
                .cin  (carry[gi]),
                .s    (diff[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign borrow = ~carry[N];
endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider. It produces one quotient bit per clock, MSB first.
// Latency is fixed from accept to done, and the divider takes a new start in the cycle after done.
// Optional feature: define SEQ_DIVIDER_DBZ_EN to add the div_by_zero output.
// With that macro defined, a zero divisor bypasses the iterations.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef SEQ_DIVIDER_DBZ_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_reg;
    logic [WIDTH:0]   prem_reg;     // partial remainder, one guard bit wider than operands
    logic [WIDTH-1:0] shift_reg;    // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [WIDTH-1:0] divisor_reg;
    logic [CW-1:0]    iter_reg;

`ifdef SEQ_DIVIDER_DBZ_EN
    logic             dbz_flag_reg; // current operation had a zero divisor
    logic             dbz_hold_reg; // one settling cycle so the zero-divisor result lands 2 cycles after accept
`endif

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             borrow;

    // The next dividend bit is shifted into the partial remainder before the trial subtract.
    assign trial = {prem_reg[WIDTH-1:0], shift_reg[WIDTH-1]};

    rca_sub #(
        .N (WIDTH + 1)
    ) u_rca_sub (
        .a      (trial),
        .b      ({1'b0, divisor_reg}),
        .diff   (diff),
        .borrow (borrow)
    );

    // Controller and datapath. Outputs are registered, and results change only on the edge that raises done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            prem_reg     <= '0;
            shift_reg    <= '0;
            divisor_reg  <= '0;
            iter_reg     <= '0;
`ifdef SEQ_DIVIDER_DBZ_EN
            div_by_zero  <= 1'b0;
            dbz_flag_reg <= 1'b0;
            dbz_hold_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy        <= 1'b1;
                        divisor_reg <= divisor;
                        iter_reg    <= '0;
`ifdef SEQ_DIVIDER_DBZ_EN
                        if (divisor == '0) begin
                            // Preload the saturated result and go straight to the result stage.
                            shift_reg    <= '1;
                            prem_reg     <= {1'b0, dividend};
                            dbz_flag_reg <= 1'b1;
                            dbz_hold_reg <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            shift_reg    <= dividend;
                            prem_reg     <= '0;
                            dbz_flag_reg <= 1'b0;
                            dbz_hold_reg <= 1'b0;
                            state_reg    <= RUN;
                        end
`else
                        shift_reg <= dividend;
                        prem_reg  <= '0;
                        state_reg <= RUN;
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end

                RUN: begin
                    // Keep the difference when there is no borrow; otherwise restore the shifted value.
                    prem_reg  <= borrow ? trial : diff;
                    shift_reg <= {shift_reg[WIDTH-2:0], ~borrow};
                    iter_reg  <= iter_reg + 1'b1;
                    if (iter_reg == CW'(WIDTH - 1)) begin
                        state_reg <= DONE;
                    end
                end

                DONE: begin
`ifdef SEQ_DIVIDER_DBZ_EN
                    if (dbz_hold_reg) begin
                        dbz_hold_reg <= 1'b0;
                    end else begin
                        quotient    <= shift_reg;
                        remainder   <= prem_reg[WIDTH-1:0];
                        div_by_zero <= dbz_flag_reg;
                        done        <= 1'b1;
                        state_reg   <= IDLE;
                    end
`else
                    quotient  <= shift_reg;
                    remainder <= prem_reg[WIDTH-1:0];
                    done      <= 1'b1;
                    state_reg <= IDLE;
`endif
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider (WIDTH=8). It uses directed vectors with hand-computed results.
// The stimulus process pushes expectations into a scoreboard queue.
// A monitor pops and checks an entry whenever done is seen.
module tb_seq_divider;

    localparam int W = 8;
`ifdef SEQ_DIVIDER_DBZ_EN
    localparam bit DBZ = 1'b1;
`else
    localparam bit DBZ = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
`ifdef SEQ_DIVIDER_DBZ_EN
    logic         div_by_zero;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           start_cycle;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    int           cycle  = 0;
    bit           mon_en = 1'b0;
    logic [W-1:0] held_q = '0;
    logic [W-1:0] held_r = '0;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder)
`ifdef SEQ_DIVIDER_DBZ_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: checks each done pulse against the scoreboard and verifies the outputs hold steady otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("done: q=%0d r=%0d latency=%0d", quotient, remainder, cycle - e.start_cycle);
                    chk("quotient", 32'(quotient), 32'(e.q));
                    chk("remainder", 32'(remainder), 32'(e.r));
                    chk("latency", 32'(cycle - e.start_cycle), 32'(e.lat));
                    chk("busy_at_done", 32'(busy), 32'd1);
`ifdef SEQ_DIVIDER_DBZ_EN
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
`endif
                    held_q = e.q;
                    held_r = e.r;
                end
            end else begin
                chk("quotient_stable", 32'(quotient), 32'(held_q));
                chk("remainder_stable", 32'(remainder), 32'(held_r));
            end
        end
    end

    // Issues one start pulse and records the expected result together with the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r);
        exp_t e;
        @(posedge clk);
        #2;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        e.q           = q;
        e.r           = r;
        e.dbz         = DBZ && (b == '0);
        e.lat         = (DBZ && (b == '0)) ? 2 : W + 1;
        e.start_cycle = cycle;
        sb.push_back(e);
        $display("issue: %0d / %0d -> expect q=%0d r=%0d", a, b, q, r);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Waits, with a cycle budget, for the scoreboard to empty. It can then also check that the divider went idle.
    task automatic drain(input bit check_idle);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        if (check_idle) begin
            @(negedge clk);
            #1;
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("busy_cleared", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        mon_en = 1'b1;

        issue(8'd100, 8'd7, 8'd14, 8'd2);     drain(1'b1);
        issue(8'd255, 8'd1, 8'd255, 8'd0);    drain(1'b1);
        issue(8'd5, 8'd9, 8'd0, 8'd5);        drain(1'b1);
        issue(8'd200, 8'd200, 8'd1, 8'd0);    drain(1'b1);
        issue(8'd77, 8'd0, 8'd255, 8'd77);    drain(1'b1);

        // A start pulse with 9/3 arrives during a run and must be ignored.
        issue(8'd100, 8'd7, 8'd14, 8'd2);
        repeat (2) @(posedge clk);
        #2;
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain(1'b0);
        issue(8'd9, 8'd3, 8'd3, 8'd0);        drain(1'b1);

        // Reset is asserted on the 4th iteration edge of a run and must abort it without a done pulse.
        issue(8'd100, 8'd7, 8'd14, 8'd2);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        held_q = '0;
        held_r = '0;
        $display("reset: aborted run in progress");
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        repeat (12) @(negedge clk);
        issue(8'd50, 8'd6, 8'd8, 8'd2);       drain(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
